ptp_bus_arbiter: RTL and testbench
==================================

// Module: ptp_bus_arbiter
// PURPOSE
//  Shares the 32-bit on-chip register bus of ptpv2_core between two masters:
//  M0 = host CPU bridge, M1 = autonomous servo/timestamp-readout engine.
//  Round-robin arbitration, one transaction in flight, optional lock so a
//  master can read multi-word values (e.g. RTC sec + ns) without interleaving.
//  Sits between the two masters and the bus2ip_* / ip2bus_data ports of the core.
// PARAMETERS
//  ADDR_W   32  address width
//  DATA_W   32  data width
//  RD_LAT   1   cycles from bus2ip_rd_ce_o high to valid ip2bus_data_i (1..7)
// PORTS
//  bus2ip_clk      in   1       single clock, all logic on rising edge
//  bus2ip_rst      in   1       synchronous reset, active high
//  mN_req_i        in   1       (N=0,1) request; hold with cmd fields until ack
//  mN_we_i         in   1       1 = write, 0 = read
//  mN_lock_i       in   1       keep ownership after this transaction
//  mN_addr_i       in   ADDR_W  register address
//  mN_wdata_i      in   DATA_W  write data
//  mN_ack_o        out  1       one-cycle completion pulse
//  mN_rdata_o      out  DATA_W  read data, valid while mN_ack_o=1
//  bus2ip_addr_o   out  ADDR_W  to core
//  bus2ip_data_o   out  DATA_W  to core
//  bus2ip_rd_ce_o  out  1       to core, one-cycle strobe
//  bus2ip_wr_ce_o  out  1       to core, one-cycle strobe
//  ip2bus_data_i   in   DATA_W  from core
//  owner_o         out  1       index of current/last granted master
//  busy_o          out  1       1 when FSM not IDLE
// BEHAVIOUR
//  Reset: all outputs 0; FSM=IDLE; last-served=M1 (so M0 wins first); lock clear.
//  FSM: IDLE -> CMD -> (RD: WAIT) -> ACK -> IDLE.
//  IDLE: no req -> stay. Lock held and owner req=1 -> owner wins. Lock held,
//   owner req=0 -> stay IDLE (other master blocked). Else one req -> it wins;
//   both -> master not last served wins. Winner's we/addr/wdata/lock latched;
//   owner_o updated; go CMD next cycle.
//  CMD (1 cycle): addr/data driven from latch; wr_ce_o=we or rd_ce_o=~we for
//   exactly this cycle. Write -> ACK. Read -> WAIT, counter loaded RD_LAT.
//  WAIT: count down; in the cycle counter reaches 0 (RD_LAT cycles after CMD)
//   sample ip2bus_data_i into rdata register -> ACK.
//  ACK (1 cycle): mN_ack_o=1 for owner only, mN_rdata_o=sampled data (reads;
//   writes drive 0). Lock flag <= latched lock bit. Last-served <= owner. -> IDLE.
//  Latency: req seen in IDLE at T; CMD T+1; write ack T+2; read ack T+2+RD_LAT.
//  Back-to-back: a master holding req after ack is re-arbitrated in IDLE; min
//   spacing between strobes = 3 cycles (write), 3+RD_LAT (read).
//  bus2ip_addr_o/data_o hold last values outside CMD; rd/wr strobes 0 outside CMD.
//  mN_rdata_o is 0 except in owner's ACK cycle.
//  req dropped after grant: transaction still completes, ack still pulses.
//  Lock released only by an ACK whose latched lock bit is 0.
//  Reset mid-transaction: strobes/ack drop next edge, no ack issued, lock cleared.
// TESTING
//  Reset then M0 read addr 0x10, RD_LAT=1, core returns 0xA5A5_0001 -> rd_ce 1
//   cycle at T+1, m0_ack at T+3 with m0_rdata=0xA5A5_0001, m1_ack stays 0.
//  M1 write 0x20<=0x1234 -> wr_ce at T+1 with addr 0x20, data 0x1234; ack T+2.
//  Both req continuous (reads) -> grants alternate M0,M1,M0,M1; each ack
//   rdata matches its own address; no strobe overlap.
//  M1 lock=1 on read 0x08, then lock=0 on read 0x0C, M0 req throughout ->
//   M1 gets both before M0; M0 granted only after second M1 ack.
//  Assert reset in WAIT of a read -> no ack, busy_o=0, strobes 0 next cycle;
//   after release simultaneous req -> M0 served first.
//  Sweep RD_LAT 1..4 -> ack exactly 2+RD_LAT cycles after req sampling.

Source files
------------

// File: rtl/ptp_bus_arbiter_if.sv
// ----------------------------------------------------------------------------
// ptp_bus_arbiter_if
//   Request/response channel between one register-bus master and the
//   ptp_bus_arbiter. One instance per master.
//
//   req    master -> arbiter  request; held with the command fields until ack
//   we     master -> arbiter  1 = write, 0 = read
//   lock   master -> arbiter  keep bus ownership after this transaction
//   addr   master -> arbiter  register address
//   wdata  master -> arbiter  write data
//   ack    arbiter -> master  one-cycle completion pulse
//   rdata  arbiter -> master  read data, valid only while ack = 1
// ----------------------------------------------------------------------------
interface ptp_bus_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              req;
    logic              we;
    logic              lock;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              ack;
    logic [DATA_W-1:0] rdata;

    modport master (output req, we, lock, addr, wdata, input ack, rdata);
    modport slave  (input req, we, lock, addr, wdata, output ack, rdata);
endinterface

// File: rtl/ptp_bus_arbiter.sv
// ----------------------------------------------------------------------------
// ptp_bus_arbiter
//   Shares the ptpv2_core register bus between two masters (m0 = host CPU
//   bridge, m1 = servo/timestamp-readout engine). Round-robin arbitration,
//   one transaction in flight, and an optional lock that keeps ownership with
//   one master so multi-word values can be read without interleaving.
//
//   Parameters
//     ADDR_W  address width
//     DATA_W  data width
//     RD_LAT  cycles from bus2ip_rd_ce_o high to valid ip2bus_data_i (1..7)
//
//   Ports
//     bus2ip_clk      in   clock, everything on the rising edge
//     bus2ip_rst      in   synchronous reset, active high
//     m0, m1          slave side of each master's request channel
//     bus2ip_addr_o   out  address to core (holds last value outside CMD)
//     bus2ip_data_o   out  write data to core (holds last value outside CMD)
//     bus2ip_rd_ce_o  out  one-cycle read strobe
//     bus2ip_wr_ce_o  out  one-cycle write strobe
//     ip2bus_data_i   in   read data from core
//     owner_o         out  index of the current / last granted master
//     busy_o          out  1 whenever the FSM is not IDLE
// ----------------------------------------------------------------------------
module ptp_bus_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int RD_LAT = 1
) (
    input  logic              bus2ip_clk,
    input  logic              bus2ip_rst,
    ptp_bus_arbiter_if.slave  m0,
    ptp_bus_arbiter_if.slave  m1,
    output logic [ADDR_W-1:0] bus2ip_addr_o,
    output logic [DATA_W-1:0] bus2ip_data_o,
    output logic              bus2ip_rd_ce_o,
    output logic              bus2ip_wr_ce_o,
    input  logic [DATA_W-1:0] ip2bus_data_i,
    output logic              owner_o,
    output logic              busy_o
);
    localparam int CNT_W = 3;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CMD,
        ST_WAIT,
        ST_ACK
    } state_t;

    state_t            state_q, state_d;
    logic              owner_q;      // granted master (lock owner while lock_q=1)
    logic              last_q;       // last master served, loses the next tie
    logic              lock_q;       // bus reserved for owner_q
    logic              we_q;
    logic              lk_q;         // lock bit latched with the command
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] rdata_q;
    logic [CNT_W-1:0]  cnt_q;

    logic              grant;
    logic              gsel;

    // Next state, arbitration and output decode.
    // NOTE: every signal written here gets a default first; a path that
    // leaves one unassigned would infer a latch.
    always_comb begin
        state_d        = state_q;
        grant          = 1'b0;
        gsel           = 1'b0;
        bus2ip_rd_ce_o = 1'b0;
        bus2ip_wr_ce_o = 1'b0;
        m0.ack         = 1'b0;
        m1.ack         = 1'b0;
        m0.rdata       = '0;
        m1.rdata       = '0;

        case (state_q)
            ST_IDLE: begin
                if (lock_q) begin
                    // Reserved bus: only the lock owner can start; the other
                    // master waits even if the owner is not requesting.
                    gsel  = owner_q;
                    grant = owner_q ? m1.req : m0.req;
                end else if (m0.req && m1.req) begin
                    gsel  = ~last_q;
                    grant = 1'b1;
                end else if (m0.req || m1.req) begin
                    gsel  = m1.req;
                    grant = 1'b1;
                end
                if (grant) state_d = ST_CMD;
            end
            ST_CMD: begin
                bus2ip_wr_ce_o = we_q;
                bus2ip_rd_ce_o = ~we_q;
                state_d        = we_q ? ST_ACK : ST_WAIT;
            end
            ST_WAIT: begin
                if (cnt_q == CNT_W'(1)) state_d = ST_ACK;
            end
            ST_ACK: begin
                m0.ack   = ~owner_q;
                m1.ack   = owner_q;
                m0.rdata = (~owner_q && ~we_q) ? rdata_q : '0;
                m1.rdata = ( owner_q && ~we_q) ? rdata_q : '0;
                state_d  = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge bus2ip_clk) begin
        if (bus2ip_rst) state_q <= ST_IDLE;
        else            state_q <= state_d;
    end

    // Command latch, read-latency counter and arbitration history.
    // NOTE: the datapath registers are reset as well because they drive
    // outputs directly and every output must read 0 out of reset.
    always_ff @(posedge bus2ip_clk) begin
        if (bus2ip_rst) begin
            owner_q <= 1'b0;
            last_q  <= 1'b1;   // m0 wins the first tie
            lock_q  <= 1'b0;
            we_q    <= 1'b0;
            lk_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            cnt_q   <= '0;
        end else begin
            if (state_q == ST_IDLE && grant) begin
                owner_q <= gsel;
                we_q    <= gsel ? m1.we    : m0.we;
                lk_q    <= gsel ? m1.lock  : m0.lock;
                addr_q  <= gsel ? m1.addr  : m0.addr;
                wdata_q <= gsel ? m1.wdata : m0.wdata;
            end
            if (state_q == ST_CMD) cnt_q <= CNT_W'(RD_LAT);
            if (state_q == ST_WAIT) begin
                cnt_q <= cnt_q - CNT_W'(1);
                // Last WAIT cycle is RD_LAT cycles after the read strobe.
                if (cnt_q == CNT_W'(1)) rdata_q <= ip2bus_data_i;
            end
            if (state_q == ST_ACK) begin
                lock_q <= lk_q;
                last_q <= owner_q;
            end
        end
    end

    assign bus2ip_addr_o = addr_q;
    assign bus2ip_data_o = wdata_q;
    assign owner_o       = owner_q;
    assign busy_o        = (state_q != ST_IDLE);
endmodule

// File: tb/tb_ptp_bus_arbiter.sv
// ----------------------------------------------------------------------------
// tb_ptp_bus_arbiter
//   Directed vector table, hand-written lock / back-to-back / reset
//   sequences, a randomized run against a transaction-timeline model, and an
//   RD_LAT sweep on extra instances (RD_LAT = 2..4).
// ----------------------------------------------------------------------------
module tb_ptp_bus_arbiter;
    localparam int MAIN_LAT = 1;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int sweep_turn = 0;
    always @(posedge clk) cyc <= cyc + 1;

    ptp_bus_arbiter_if m0 ();
    ptp_bus_arbiter_if m1 ();

    logic [31:0] bus_addr, bus_data, ip_data;
    logic        rd_ce, wr_ce, owner, busy;

    ptp_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .RD_LAT(MAIN_LAT)) dut (
        .bus2ip_clk     (clk),
        .bus2ip_rst     (rst),
        .m0             (m0),
        .m1             (m1),
        .bus2ip_addr_o  (bus_addr),
        .bus2ip_data_o  (bus_data),
        .bus2ip_rd_ce_o (rd_ce),
        .bus2ip_wr_ce_o (wr_ce),
        .ip2bus_data_i  (ip_data),
        .owner_o        (owner),
        .busy_o         (busy)
    );

    // Register contents of the fake core.
    function automatic logic [31:0] core_data(input logic [31:0] a);
        return (a == 32'h10) ? 32'hA5A5_0001 : (32'h5A00_0000 ^ a ^ (a << 12));
    endfunction

    // Fake core: read data is valid only in the cycle RD_LAT after the strobe.
    int          rd_cyc = -100;
    logic [31:0] rd_addr = '0;
    always @(posedge clk) if (rd_ce) begin rd_cyc <= cyc; rd_addr <= bus_addr; end
    assign ip_data = (cyc == rd_cyc + MAIN_LAT) ? core_data(rd_addr) : 32'hDEAD_BEEF;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
        end
    endtask

    task automatic set_m(input int idx, input logic req, input logic we, input logic lock,
                         input logic [31:0] addr, input logic [31:0] wdata);
        if (idx == 0) begin
            m0.req = req; m0.we = we; m0.lock = lock; m0.addr = addr; m0.wdata = wdata;
        end else begin
            m1.req = req; m1.we = we; m1.lock = lock; m1.addr = addr; m1.wdata = wdata;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        set_m(0, 0, 0, 0, 0, 0);
        set_m(1, 0, 0, 0, 0, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    typedef struct {
        logic        r0, r1, we;
        logic [31:0] a0, d0, a1, d1;
        int          win, lat;
        logic [31:0] rdat;
    } vec_t;

    // ------------------------------------------------------------------
    // RD_LAT sweep on separate instances
    // ------------------------------------------------------------------
    for (genvar g = 2; g <= 4; g++) begin : g_sweep
        ptp_bus_arbiter_if s0 ();
        ptp_bus_arbiter_if s1 ();
        logic [31:0] s_addr, s_data, s_ip;
        logic        s_rd, s_wr, s_own, s_busy;
        int          s_rd_cyc = -100;
        logic [31:0] s_rd_addr = '0;

        ptp_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .RD_LAT(g)) u_dut (
            .bus2ip_clk     (clk),
            .bus2ip_rst     (rst),
            .m0             (s0),
            .m1             (s1),
            .bus2ip_addr_o  (s_addr),
            .bus2ip_data_o  (s_data),
            .bus2ip_rd_ce_o (s_rd),
            .bus2ip_wr_ce_o (s_wr),
            .ip2bus_data_i  (s_ip),
            .owner_o        (s_own),
            .busy_o         (s_busy)
        );

        always @(posedge clk) if (s_rd) begin s_rd_cyc <= cyc; s_rd_addr <= s_addr; end
        assign s_ip = (cyc == s_rd_cyc + g) ? core_data(s_rd_addr) : 32'hDEAD_BEEF;

        initial begin
            int          off;
            logic [31:0] got;
            s0.req = 0; s0.we = 0; s0.lock = 0; s0.addr = 0; s0.wdata = 0;
            s1.req = 0; s1.we = 0; s1.lock = 0; s1.addr = 0; s1.wdata = 0;
            wait (sweep_turn == g);
            @(negedge clk);
            s0.req = 1; s0.addr = 32'h40 + g; s0.wdata = 32'hC0DE_0000 | g;
            off = -1; got = '0;
            for (int k = 1; k <= 12; k++) begin
                @(negedge clk);
                if (k == 1) begin
                    check($sformatf("sweep%0d_rd_ce", g), {31'b0, s_rd}, 1);
                    check($sformatf("sweep%0d_wr_ce", g), {31'b0, s_wr}, 0);
                    check($sformatf("sweep%0d_cmd_data", g), s_data, 32'hC0DE_0000 | g);
                end
                if (s0.ack && off < 0) begin off = k; got = s0.rdata; s0.req = 0; end
            end
            check($sformatf("sweep%0d_lat", g), off, 2 + g);
            check($sformatf("sweep%0d_rdata", g), got, core_data(32'h40 + g));
            check($sformatf("sweep%0d_idle", g), {30'b0, s_busy, s_own}, 0);
            sweep_turn = g + 1;
        end
    end

    // ------------------------------------------------------------------
    // Main sequence
    // ------------------------------------------------------------------
    initial begin
        vec_t        vec [7];
        int          off, who_a, nack, n, ns, phase, pause;
        int          who [4];
        int          st  [4];
        logic [31:0] dat [4];
        logic [31:0] got;
        bit          m0_done;
        // random-run model state
        int          c, next_free, last, lock_own, cur_m, cmd_c, ack_c, w;
        bit          cur_v, cur_we, cur_lk;
        logic [31:0] cur_a, cur_d, exp_rd0, exp_rd1;
        bit          pend [2];
        bit          p_we [2], p_lk [2];
        logic [31:0] p_a [2], p_d [2];

        vec[0] = '{1'b1, 1'b0, 1'b0, 32'h10, 32'h0,  32'h0,  32'h0,    0, 3, 32'hA5A5_0001};
        vec[1] = '{1'b0, 1'b1, 1'b1, 32'h0,  32'h0,  32'h20, 32'h1234, 1, 2, 32'h0};
        vec[2] = '{1'b1, 1'b1, 1'b0, 32'h30, 32'h0,  32'h34, 32'h0,    0, 3, core_data(32'h30)};
        vec[3] = '{1'b1, 1'b1, 1'b0, 32'h38, 32'h0,  32'h3C, 32'h0,    1, 3, core_data(32'h3C)};
        vec[4] = '{1'b1, 1'b1, 1'b1, 32'h50, 32'h11, 32'h54, 32'h22,   0, 2, 32'h0};
        vec[5] = '{1'b1, 1'b0, 1'b1, 32'h58, 32'h33, 32'h0,  32'h0,    0, 2, 32'h0};
        vec[6] = '{1'b1, 1'b1, 1'b0, 32'h5C, 32'h0,  32'h60, 32'h0,    1, 3, core_data(32'h60)};

        // Reset state
        rst = 1'b1;
        set_m(0, 0, 0, 0, 0, 0);
        set_m(1, 0, 0, 0, 0, 0);
        repeat (2) @(negedge clk);
        check("rst_ack", {30'b0, m1.ack, m0.ack}, 0);
        check("rst_rdata0", m0.rdata, 0);
        check("rst_rdata1", m1.rdata, 0);
        check("rst_strobes", {30'b0, rd_ce, wr_ce}, 0);
        check("rst_owner_busy", {30'b0, owner, busy}, 0);
        check("rst_addr", bus_addr, 0);
        check("rst_data", bus_data, 0);
        rst = 1'b0;

        // Single transactions from IDLE
        for (int i = 0; i < 7; i++) begin
            set_m(0, vec[i].r0, vec[i].we, 0, vec[i].a0, vec[i].d0);
            set_m(1, vec[i].r1, vec[i].we, 0, vec[i].a1, vec[i].d1);
            off = -1; who_a = -1; got = '0; nack = 0;
            for (int k = 1; k <= 6; k++) begin
                @(negedge clk);
                if (k == 1) begin
                    check($sformatf("vec%0d_wr_ce", i), {31'b0, wr_ce}, {31'b0, vec[i].we});
                    check($sformatf("vec%0d_rd_ce", i), {31'b0, rd_ce}, {31'b0, ~vec[i].we});
                    check($sformatf("vec%0d_addr", i), bus_addr, (vec[i].win == 1) ? vec[i].a1 : vec[i].a0);
                    check($sformatf("vec%0d_owner", i), {31'b0, owner}, vec[i].win);
                    if (vec[i].we)
                        check($sformatf("vec%0d_wdata", i), bus_data, (vec[i].win == 1) ? vec[i].d1 : vec[i].d0);
                end else begin
                    check($sformatf("vec%0d_no_strobe", i), {30'b0, rd_ce, wr_ce}, 0);
                end
                if (m0.ack || m1.ack) begin
                    nack = nack + (m0.ack ? 1 : 0) + (m1.ack ? 1 : 0);
                    if (off < 0) begin off = k; who_a = m1.ack ? 1 : 0; got = m1.ack ? m1.rdata : m0.rdata; end
                    m0.req = 0; m1.req = 0;
                end
            end
            check($sformatf("vec%0d_lat", i), off, vec[i].lat);
            check($sformatf("vec%0d_who", i), who_a, vec[i].win);
            check($sformatf("vec%0d_rdata", i), got, vec[i].rdat);
            check($sformatf("vec%0d_nack", i), nack, 1);
        end

        // Lock: M1 locked read 0x08, pause, unlocked read 0x0C; M0 waits throughout
        set_m(1, 1, 0, 1, 32'h08, 0);
        @(negedge clk);
        set_m(0, 1, 0, 0, 32'h60, 0);
        n = 0; phase = 0; pause = 0; m0_done = 0;
        for (int k = 0; k < 60 && !(m0_done && phase == 3); k++) begin
            @(negedge clk);
            if (phase == 1) begin
                check("lock_blocks_m0", {31'b0, busy}, 0);
                if (pause == 0) begin set_m(1, 1, 0, 0, 32'h0C, 0); phase = 2; end
                else pause--;
            end
            if (m0.ack || m1.ack) begin
                if (n < 4) begin who[n] = m1.ack ? 1 : 0; dat[n] = m1.ack ? m1.rdata : m0.rdata; end
                n++;
            end
            if (m1.ack) begin
                m1.req = 0;
                if (phase == 0) begin phase = 1; pause = 2; end else phase = 3;
            end
            if (m0.ack) begin m0.req = 0; m0_done = 1; end
        end
        check("lock_nack", n, 3);
        check("lock_who0", who[0], 1);
        check("lock_dat0", dat[0], core_data(32'h08));
        check("lock_who1", who[1], 1);
        check("lock_dat1", dat[1], core_data(32'h0C));
        check("lock_who2", who[2], 0);
        check("lock_dat2", dat[2], core_data(32'h60));

        // Both masters requesting continuously: alternate, own data, strobe spacing
        set_m(0, 1, 0, 0, 32'h100, 0);
        set_m(1, 1, 0, 0, 32'h200, 0);
        n = 0; ns = 0;
        for (int k = 0; k < 60 && n < 4; k++) begin
            @(negedge clk);
            if (rd_ce || wr_ce) begin if (ns < 4) st[ns] = k; ns++; end
            if (m0.ack || m1.ack) begin
                who[n] = m1.ack ? 1 : 0;
                dat[n] = m1.ack ? m1.rdata : m0.rdata;
                n++;
            end
            if (n == 4) begin m0.req = 0; m1.req = 0; end
        end
        check("alt_nack", n, 4);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("alt_who%0d", i), who[i], (i % 2 == 0) ? 1 : 0);
            check($sformatf("alt_dat%0d", i), dat[i], core_data((i % 2 == 0) ? 32'h200 : 32'h100));
        end
        check("alt_space01", st[1] - st[0], 3 + MAIN_LAT);
        check("alt_space23", st[3] - st[2], 3 + MAIN_LAT);
        repeat (4) @(negedge clk);

        // Request dropped right after grant still completes
        set_m(0, 1, 1, 0, 32'h70, 32'h77);
        @(negedge clk);
        check("drop_wr_ce", {31'b0, wr_ce}, 1);
        m0.req = 0;
        @(negedge clk);
        check("drop_ack", {31'b0, m0.ack}, 1);
        @(negedge clk);

        // Reset during WAIT, with M1 holding the lock beforehand
        set_m(1, 1, 0, 1, 32'h08, 0);
        off = -1;
        for (int k = 1; k <= 10 && off < 0; k++) begin
            @(negedge clk);
            if (m1.ack) begin off = k; m1.req = 0; end
        end
        check("rstw_lock_ack", off, 2 + MAIN_LAT);
        @(negedge clk);
        set_m(1, 1, 0, 0, 32'h0C, 0);
        @(negedge clk);
        check("rstw_rd_ce", {31'b0, rd_ce}, 1);
        @(negedge clk);
        check("rstw_busy_wait", {31'b0, busy}, 1);
        rst = 1'b1;
        @(negedge clk);
        check("rstw_busy", {31'b0, busy}, 0);
        check("rstw_ack", {30'b0, m1.ack, m0.ack}, 0);
        check("rstw_strobes", {30'b0, rd_ce, wr_ce}, 0);
        m1.req = 0;
        rst = 1'b0;
        @(negedge clk);
        set_m(0, 1, 0, 0, 32'h80, 0);
        set_m(1, 1, 0, 0, 32'h84, 0);
        who_a = -1;
        for (int k = 1; k <= 10 && who_a < 0; k++) begin
            @(negedge clk);
            if (m0.ack || m1.ack) begin who_a = m1.ack ? 1 : 0; m0.req = 0; m1.req = 0; end
        end
        check("rstw_first_winner", who_a, 0);

        // Randomized run against a transaction-timeline model
        do_reset();
        next_free = 0; last = 1; lock_own = -1; cur_v = 0;
        cur_m = 0; cur_we = 0; cur_lk = 0; cur_a = 0; cur_d = 0; cmd_c = -1; ack_c = -1;
        for (int m = 0; m < 2; m++) begin pend[m] = 0; p_we[m] = 0; p_lk[m] = 0; p_a[m] = 0; p_d[m] = 0; end
        for (c = 0; c < 1500; c++) begin
            exp_rd0 = (cur_v && c == ack_c && cur_m == 0 && !cur_we) ? core_data(cur_a) : 32'h0;
            exp_rd1 = (cur_v && c == ack_c && cur_m == 1 && !cur_we) ? core_data(cur_a) : 32'h0;
            check("rnd_ack0", {31'b0, m0.ack}, (cur_v && c == ack_c && cur_m == 0) ? 1 : 0);
            check("rnd_ack1", {31'b0, m1.ack}, (cur_v && c == ack_c && cur_m == 1) ? 1 : 0);
            check("rnd_rdata0", m0.rdata, exp_rd0);
            check("rnd_rdata1", m1.rdata, exp_rd1);
            check("rnd_rd_ce", {31'b0, rd_ce}, (cur_v && c == cmd_c && !cur_we) ? 1 : 0);
            check("rnd_wr_ce", {31'b0, wr_ce}, (cur_v && c == cmd_c && cur_we) ? 1 : 0);
            check("rnd_busy", {31'b0, busy}, (cur_v && c >= cmd_c && c <= ack_c) ? 1 : 0);
            if (cur_v && c == cmd_c) begin
                check("rnd_addr", bus_addr, cur_a);
                check("rnd_owner", {31'b0, owner}, cur_m);
                if (cur_we) check("rnd_wdata", bus_data, cur_d);
            end
            if (cur_v && c == ack_c) begin
                pend[cur_m] = 0;
                set_m(cur_m, 0, 0, 0, 0, 0);
                lock_own = cur_lk ? cur_m : -1;
                last = cur_m;
                cur_v = 0;
            end
            for (int m = 0; m < 2; m++) begin
                if (!pend[m] && (lock_own == m || $urandom_range(0, 2) == 0)) begin
                    pend[m] = 1;
                    p_we[m] = $urandom_range(0, 1) == 1;
                    p_lk[m] = $urandom_range(0, 7) == 0;
                    p_a[m]  = $urandom();
                    p_d[m]  = $urandom();
                    set_m(m, 1, p_we[m], p_lk[m], p_a[m], p_d[m]);
                end
            end
            if (!cur_v && c >= next_free) begin
                w = -1;
                if (lock_own >= 0)          w = pend[lock_own] ? lock_own : -1;
                else if (pend[0] && pend[1]) w = 1 - last;
                else if (pend[0])            w = 0;
                else if (pend[1])            w = 1;
                if (w >= 0) begin
                    cur_v = 1; cur_m = w; cur_we = p_we[w]; cur_lk = p_lk[w];
                    cur_a = p_a[w]; cur_d = p_d[w];
                    cmd_c = c + 1;
                    ack_c = c + 2 + (cur_we ? 0 : MAIN_LAT);
                    next_free = ack_c + 1;
                end
            end
            @(negedge clk);
        end
        set_m(0, 0, 0, 0, 0, 0);
        set_m(1, 0, 0, 0, 0, 0);

        // RD_LAT sweep instances, one after another
        sweep_turn = 2;
        for (int i = 0; i < 200 && sweep_turn != 5; i++) @(negedge clk);
        check("sweep_done", sweep_turn, 5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
